// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_excitation_driver
// Description : Drives a bank of WIDTH JK storage elements toward a requested
//               target word. It derives per-bit J/K commands from the JK
//               excitation table, then sequences a clock-enable strobe. A
//               shadow copy of the bank's Q is kept, so the bank is never
//               read back.
//
// Ports       : Clk          - system clock, rising edge
//               Rst          - synchronous, active-high reset
//               tgt_valid    - target word offered
//               tgt_ready    - target can be accepted (IDLE, no shadow load)
//               tgt_data     - desired bank state
//               shadow_load  - overwrite the shadow with shadow_data (IDLE)
//               shadow_data  - value for shadow_load
//               J, K         - per-bit drive to the JK bank
//               strobe       - bank clock-enable, PULSE_LEN cycles per update
//               done         - one-cycle pulse when an update completes
//               chg_cnt      - number of bits changed by the last update
//               q_shadow     - tracked bank state
//
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excitation_driver #(
  parameter int WIDTH     = 8,
  parameter int PULSE_LEN = 1,
  parameter int DC_POLICY = 0
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       tgt_valid,
  output logic                       tgt_ready,
  input  logic [WIDTH-1:0]           tgt_data,
  input  logic                       shadow_load,
  input  logic [WIDTH-1:0]           shadow_data,
  output logic [WIDTH-1:0]           J,
  output logic [WIDTH-1:0]           K,
  output logic                       strobe,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] chg_cnt,
  output logic [WIDTH-1:0]           q_shadow
);

  localparam int CW = $clog2(WIDTH+1);

  // A pulse length of zero is meaningless; stretch it to one cycle.
  localparam int         PULSE_EFF    = (PULSE_LEN < 1) ? 1 : PULSE_LEN;
  localparam logic [3:0] PULSE_RELOAD = 4'(PULSE_EFF - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] tgt_reg;
  logic [3:0]       pulse_cnt;
  logic             accept;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [CW-1:0]    diff_cnt;

  // shadow_load takes priority over a handshake, so ready drops with it.
  assign tgt_ready = (state == IDLE) && !shadow_load && !Rst;
  assign accept    = tgt_valid && tgt_ready;
  assign strobe    = (state == PULSE) && !Rst;
  assign done      = (state == HOLD) && !Rst;

  // Bits that must change. Only these bits get a non-zero J/K command.
  assign diff = q_shadow ^ tgt_data;

  generate
    if (DC_POLICY == 1) begin : g_dc_toggle
      // Use the don't-care fill for toggle: J=K=1 flips the bit either way.
      assign j_next = diff;
      assign k_next = diff;
    end else begin : g_dc_set_reset
      // Use the don't-care fill for explicit set or reset.
      // Set the rising bits and reset the falling bits.
      assign j_next = diff & tgt_data;
      assign k_next = diff & q_shadow;
    end
  endgenerate

  always_comb begin
    diff_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff_cnt = diff_cnt + CW'(diff[i]);
    end
  end

  // The J/K vectors and chg_cnt are loaded on the accepting edge.
  // tgt_data at that edge is the value captured into tgt_reg, so the
  // result is the same as computing from tgt_reg. This way the commands
  // are already stable during SETUP, which gives the bank a full setup
  // cycle before the strobe rises.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      tgt_reg   <= '0;
      pulse_cnt <= '0;
      J         <= '0;
      K         <= '0;
      chg_cnt   <= '0;
      q_shadow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (shadow_load) begin
            q_shadow <= shadow_data;
          end else if (accept) begin
            tgt_reg <= tgt_data;
            J       <= j_next;
            K       <= k_next;
            chg_cnt <= diff_cnt;
            state   <= SETUP;
          end
        end
        SETUP: begin
          pulse_cnt <= PULSE_RELOAD;
          state     <= PULSE;
        end
        PULSE: begin
          if (pulse_cnt == 4'd0) begin
            state <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end
        HOLD: begin
          // J/K were held through this cycle for hold time; now release them.
          q_shadow <= tgt_reg;
          J        <= '0;
          K        <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_jk_excitation_driver
// Description : Self-checking bench for jk_excitation_driver. It uses two
//               instances:
//                 dut 0 : DC_POLICY 0, PULSE_LEN 1
//                 dut 1 : DC_POLICY 1, PULSE_LEN 3
//               Directed steps are followed by random updates and shadow
//               loads. These are checked against a bit-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tv [2];
  logic [7:0] td [2];
  logic       sl [2];
  logic [7:0] sd [2];
  logic       rdy[2];
  logic [7:0] jo [2];
  logic [7:0] ko [2];
  logic       stb[2];
  logic       dn [2];
  logic [3:0] cc [2];
  logic [7:0] qs [2];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q [2];
  logic [3:0] model_cc[2];

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(8), .PULSE_LEN(1), .DC_POLICY(0)) dut0 (
    .Clk(clk), .Rst(rst), .tgt_valid(tv[0]), .tgt_ready(rdy[0]),
    .tgt_data(td[0]), .shadow_load(sl[0]), .shadow_data(sd[0]),
    .J(jo[0]), .K(ko[0]), .strobe(stb[0]), .done(dn[0]),
    .chg_cnt(cc[0]), .q_shadow(qs[0])
  );

  jk_excitation_driver #(.WIDTH(8), .PULSE_LEN(3), .DC_POLICY(1)) dut1 (
    .Clk(clk), .Rst(rst), .tgt_valid(tv[1]), .tgt_ready(rdy[1]),
    .tgt_data(td[1]), .shadow_load(sl[1]), .shadow_data(sd[1]),
    .J(jo[1]), .K(ko[1]), .strobe(stb[1]), .done(dn[1]),
    .chg_cnt(cc[1]), .q_shadow(qs[1])
  );

  task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, s, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Excitation-table reference, applied one bit at a time.
  task automatic ref_jk(input logic [7:0] q, input logic [7:0] t, input bit toggle,
                        output logic [7:0] j, output logic [7:0] k);
    for (int b = 0; b < 8; b++) begin
      if (q[b] == t[b])  begin j[b] = 1'b0; k[b] = 1'b0; end
      else if (toggle)   begin j[b] = 1'b1; k[b] = 1'b1; end
      else if (t[b])     begin j[b] = 1'b1; k[b] = 1'b0; end
      else               begin j[b] = 1'b0; k[b] = 1'b1; end
    end
  endtask

  function automatic logic [3:0] changed_bits(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) if (a[i] != b[i]) n++;
    return 4'(n);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_J", s, jo[s], 0);
      chk("rst_K", s, ko[s], 0);
      chk("rst_strobe", s, stb[s], 0);
      chk("rst_done", s, dn[s], 0);
      chk("rst_cnt", s, cc[s], 0);
      chk("rst_q", s, qs[s], 0);
      chk("rst_ready", s, rdy[s], 0);
      model_q[s]  = 8'h00;
      model_cc[s] = 4'h0;
    end
    rst = 1'b0;
    #1;
  endtask

  // Offer target t in the current IDLE cycle, then follow it cycle by cycle.
  task automatic update(input int s, input logic [7:0] t);
    logic [7:0] ej, ek;
    int pl;
    pl = (s == 0) ? 1 : 3;
    ref_jk(model_q[s], t, (s == 1), ej, ek);
    tv[s] = 1'b1;
    td[s] = t;
    #1;
    chk("ready_idle", s, rdy[s], 1);
    tick();
    tv[s] = 1'b0;
    td[s] = 8'($urandom);   // must not affect the captured target
    #1;
    for (int i = 1; i <= pl + 2; i++) begin
      if (i > 1) tick();
      chk("J", s, jo[s], ej);
      chk("K", s, ko[s], ek);
      chk("strobe", s, stb[s], (i >= 2 && i <= pl + 1));
      chk("done", s, dn[s], (i == pl + 2));
      chk("ready_busy", s, rdy[s], 0);
      chk("q_during", s, qs[s], model_q[s]);
    end
    tick();
    model_cc[s] = changed_bits(model_q[s], t);
    model_q[s]  = t;
    chk("ready_after", s, rdy[s], 1);
    chk("J_after", s, jo[s], 0);
    chk("K_after", s, ko[s], 0);
    chk("done_after", s, dn[s], 0);
    chk("q_after", s, qs[s], model_q[s]);
    chk("chg_cnt", s, cc[s], model_cc[s]);
  endtask

  task automatic sload(input int s, input logic [7:0] v, input logic offer, input logic [7:0] t);
    sl[s] = 1'b1;
    sd[s] = v;
    tv[s] = offer;
    td[s] = t;
    #1;
    chk("ready_sload", s, rdy[s], 0);
    tick();
    sl[s] = 1'b0;
    tv[s] = 1'b0;
    #1;
    model_q[s] = v;
    chk("q_sload", s, qs[s], v);
    chk("ready_post_sload", s, rdy[s], 1);
    tick();
    chk("no_accept_strobe", s, stb[s], 0);
    chk("no_accept_ready", s, rdy[s], 1);
    chk("no_accept_J", s, jo[s], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tv[s] = 1'b0; td[s] = 8'h00; sl[s] = 1'b0; sd[s] = 8'h00;
    end
    tick();
    do_reset();
    tick();

    // Set/reset encoding, single-cycle strobe.
    update(0, 8'hA5);
    chk("cnt_A5", 0, cc[0], 4);
    update(0, 8'h5A);
    chk("cnt_5A", 0, cc[0], 8);

    // Toggle encoding from the same starting shadow.
    sload(1, 8'hA5, 1'b0, 8'h00);
    update(1, 8'h5A);

    // Target equal to the shadow still runs a full sequence.
    sload(0, 8'h3C, 1'b0, 8'h00);
    update(0, 8'h3C);
    chk("cnt_same", 0, cc[0], 0);

    // shadow_load wins over a simultaneous offer.
    sload(0, 8'h0F, 1'b1, 8'hF0);
    update(0, 8'hF0);
    chk("cnt_F0", 0, cc[0], 8);

    // Reset during PULSE aborts the update without touching the shadow.
    do_reset();
    tv[1] = 1'b1; td[1] = 8'hFF;
    tick();
    tv[1] = 1'b0;
    tick();
    chk("abort_in_pulse", 1, stb[1], 1);
    rst = 1'b1;
    tick();
    chk("abort_J", 1, jo[1], 0);
    chk("abort_K", 1, ko[1], 0);
    chk("abort_strobe", 1, stb[1], 0);
    chk("abort_done", 1, dn[1], 0);
    chk("abort_q", 1, qs[1], 0);
    chk("abort_cnt", 1, cc[1], 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 1, rdy[1], 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 1, dn[1], 0);
    end
    model_q[0] = 8'h00;
    model_q[1] = 8'h00;

    // Three-cycle strobe, from 0x00 to 0x01.
    update(1, 8'h01);

    // Random mix of updates and shadow loads on both instances.
    for (int n = 0; n < 40; n++) begin
      int s;
      s = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        sload(s, 8'($urandom), 1'($urandom), 8'($urandom));
      else
        update(s, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Transmit-side companion for a bank of WIDTH JK storage elements: accepts a target word, derives per-bit J/K commands from the JK excitation table, and sequences a clock-enable strobe so the bank lands on the target.
- Keeps a shadow copy of the bank's Q so the excitation can be computed without reading back.
- Sits between a register-write source (valid/ready) and the JK bank's J, K and Clk-enable pins.

Parameters:
- WIDTH, 8, number of JK elements driven.
- PULSE_LEN, 1, number of cycles the strobe stays high per update (1..15).
- DC_POLICY, 0, don't-care fill. 0 selects set/reset encoding; 1 selects toggle encoding.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  block can accept a target (high only in IDLE).
- tgt_data  input  WIDTH  desired bank state.
- shadow_load  input  1  overwrite the shadow with shadow_data (IDLE only).
- shadow_data  input  WIDTH  value for shadow_load.
- J  output  WIDTH  J drive to the bank.
- K  output  WIDTH  K drive to the bank.
- strobe  output  1  bank clock-enable.
- done  output  1  one-cycle pulse when an update completes.
- chg_cnt  output  $clog2(WIDTH+1)  number of bits changed by the last update.
- q_shadow  output  WIDTH  tracked bank state.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; J=0, K=0, strobe=0, done=0, chg_cnt=0, q_shadow=0, tgt_ready=0 during the reset cycle.
  - Reset mid-update aborts immediately; no partial shadow update.
- States: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- IDLE:
  - J=K=0, strobe=0, tgt_ready=1.
  - Handshake when tgt_valid & tgt_ready: capture tgt_data into tgt_reg, go to SETUP.
  - shadow_load in the same cycle as an accept: shadow_load wins and the target is not accepted. tgt_ready is driven low that cycle.
  - shadow_load alone sets q_shadow=shadow_data next cycle.
- SETUP (1 cycle):
  - Register the J/K vectors from q_shadow and tgt_reg; strobe=0, giving the bank one cycle of setup.
  - Per bit, with q = shadow bit and t = target bit:
    - q=0, t=0: J=0, K=0.
    - q=1, t=1: J=0, K=0.
    - q=0, t=1: DC_POLICY 0 gives J=1, K=0; DC_POLICY 1 gives J=1, K=1.
    - q=1, t=0: DC_POLICY 0 gives J=0, K=1; DC_POLICY 1 gives J=1, K=1.
  - chg_cnt = popcount(q_shadow ^ tgt_reg), registered here.
- PULSE:
  - strobe=1 for exactly PULSE_LEN cycles; J/K held stable.
  - Down-counter loaded with PULSE_LEN-1 on entry.
- HOLD (1 cycle):
  - strobe=0; J/K still held for hold time.
  - q_shadow <= tgt_reg; done=1 for this single cycle.
  - Next state IDLE, where J=K=0.
- Latency: accept at cycle N gives strobe high on cycles N+2..N+1+PULSE_LEN, done at N+2+PULSE_LEN, and tgt_ready high again at N+3+PULSE_LEN.
- Target equal to shadow: full sequence still runs with J=K=0, chg_cnt=0 and done still pulses.
- tgt_data changing after accept has no effect (captured value used).
- shadow_load outside IDLE is ignored.
- Width rules:
  - chg_cnt wraps never (sized for WIDTH).
  - PULSE_LEN=0 is illegal; treat as 1.

Test Plan:
- Reset, then target 0xA5, DC_POLICY=0 -> J=0xA5 and K=0x00 from SETUP through HOLD; strobe high 1 cycle; done at accept+3; q_shadow=0xA5; chg_cnt=4.
- From shadow 0xA5, target 0x5A, DC_POLICY=0 -> J=0x5A, K=0xA5, chg_cnt=8. With DC_POLICY=1 -> J=0xFF, K=0xFF.
- Target equal to shadow (0x3C after shadow_load 0x3C) -> J=K=0 during the update, chg_cnt=0, done still pulses, q_shadow stays 0x3C.
- PULSE_LEN=3, target 0x01 from 0x00 -> strobe high exactly 3 consecutive cycles; tgt_ready low from accept+1 to accept+5 inclusive; done at accept+5.
- Rst asserted during PULSE with target 0xFF -> next cycle all outputs 0, q_shadow=0x00, state IDLE, no done pulse.
- shadow_load=1 with shadow_data=0x0F, simultaneous with tgt_valid=1 and tgt_data=0xF0 in IDLE -> no accept; q_shadow=0x0F; a later offer of 0xF0 gives chg_cnt=8.
